// File: rtl/axi_traffic_checker_if.sv
// User-side burst interface between the traffic checker (master) and the
// AXI master controller (slave): write/read burst requests plus beat handshakes.
interface axi_traffic_checker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wr_start;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  rd_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  rd_done;

  modport master (
    output wr_start, wr_addr, wr_len, wr_data, rd_start, rd_addr, rd_len,
    input  wr_ready, wr_done, rd_data, rd_vld, rd_done
  );

  modport slave (
    input  wr_start, wr_addr, wr_len, wr_data, rd_start, rd_addr, rd_len,
    output wr_ready, wr_done, rd_data, rd_vld, rd_done
  );
endinterface

// File: rtl/axi_traffic_checker.sv
// Write/read-back traffic generator: writes a pattern burst, reads it back,
// compares every beat and reports mismatch count and first failing address.
module axi_traffic_checker #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h0100_0000,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES  = 32'h0001_0000,
  parameter int                    BURST_LEN     = 16,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [15:0]              loops,
  axi_traffic_checker_if.master    bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err_flag,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [15:0]              pass_cnt
);

  localparam int                    BYTES       = DATA_WIDTH / 8;
  localparam int                    BURST_BYTES = BURST_LEN * BYTES;
  localparam int                    AW1         = ADDR_WIDTH + 1;
  localparam int                    ECW1        = ERR_CNT_WIDTH + 1;
  localparam logic [8:0]            BL9         = 9'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]   REGION_END  = AW1'(BASE_ADDR) + AW1'(REGION_BYTES);
  localparam logic [DATA_WIDTH-1:0] DW_L        = DATA_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] baddr,
                                                      input logic [8:0]            k);
    return baddr + ADDR_WIDTH'(k) * ADDR_WIDTH'(BYTES);
  endfunction

  // Beat value for pattern m; n is the running beat number across the whole run.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]            m,
                                                    input logic [31:0]           bidx,
                                                    input logic [8:0]            k,
                                                    input logic [ADDR_WIDTH-1:0] baddr);
    logic [63:0]           n64;
    logic [DATA_WIDTH-1:0] n;
    n64 = 64'(bidx) * 64'(BURST_LEN) + 64'(k);
    n   = DATA_WIDTH'(n64);
    case (m)
      2'd0:    return n;
      2'd1:    return DATA_WIDTH'(beat_addr(baddr, k));
      2'd2:    return DATA_WIDTH'(1'b1) << (n % DW_L);
      2'd3:    return n[0] ? {BYTES{8'hAA}} : {BYTES{8'h55}};
      default: return n;
    endcase
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_add(input logic [ERR_CNT_WIDTH-1:0] c,
                                                       input logic [1:0]               inc);
    logic [ERR_CNT_WIDTH:0] s;
    s = {1'b0, c} + ECW1'(inc);
    return s[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}} : s[ERR_CNT_WIDTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic                    start_q;
  logic [1:0]              mode_q, mode_d;
  logic [15:0]             loops_q, loops_d;
  logic [31:0]             bidx_q, bidx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [8:0]              wr_beat_q, wr_beat_d;
  logic [8:0]              rd_beat_q, rd_beat_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_flag_q, err_flag_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
  logic [15:0]             pass_cnt_q, pass_cnt_d;
  logic                    wr_start_q, wr_start_d;
  logic                    rd_start_q, rd_start_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                    start_edge;
  logic                    beat_bad;
  logic                    len_bad;
  logic [8:0]              beat_cnt;
  logic [1:0]              err_inc;
  logic [ADDR_WIDTH:0]     next_addr;

  // Next-state, burst bookkeeping and read-data checking.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    loops_d     = loops_q;
    bidx_d      = bidx_q;
    addr_d      = addr_q;
    wr_beat_d   = wr_beat_q;
    rd_beat_d   = rd_beat_q;
    done_d      = done_q;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_cnt_d  = pass_cnt_q;
    start_edge  = start & ~start_q;
    beat_bad    = 1'b0;
    len_bad     = 1'b0;
    beat_cnt    = rd_beat_q;
    err_inc     = 2'd0;
    next_addr   = {1'b0, addr_q} + AW1'(BURST_BYTES);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d     = S_WR_REQ;
          mode_d      = mode;
          loops_d     = loops;
          bidx_d      = 32'd0;
          addr_d      = BASE_ADDR;
          done_d      = 1'b0;
          err_flag_d  = 1'b0;
          err_cnt_d   = {ERR_CNT_WIDTH{1'b0}};
          first_err_d = {ADDR_WIDTH{1'b0}};
          pass_cnt_d  = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        // Ready pulses after the last beat are ignored.
        if (bus.wr_ready && (wr_beat_q < BL9)) begin
          wr_beat_d = wr_beat_q + 9'd1;
        end else begin
          wr_beat_d = wr_beat_q;
        end
        state_d = bus.wr_done ? S_RD_REQ : S_WR_WAIT;
      end
      S_RD_REQ: begin
        rd_beat_d = 9'd0;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // The beat of this cycle is counted before the length check on rd_done.
        // An overrun is already reported by its extra beat, so only short bursts
        // add a length error.
        beat_cnt  = (bus.rd_vld && (rd_beat_q != 9'h1FF)) ? rd_beat_q + 9'd1 : rd_beat_q;
        beat_bad  = bus.rd_vld && ((rd_beat_q >= BL9) ||
                    (bus.rd_data != pattern(mode_q, bidx_q, rd_beat_q, addr_q)));
        len_bad   = bus.rd_done && (beat_cnt < BL9);
        err_inc   = {1'b0, beat_bad} + {1'b0, len_bad};
        err_cnt_d = sat_add(err_cnt_q, err_inc);
        err_flag_d = err_flag_q | beat_bad | len_bad;
        if (!err_flag_q && beat_bad) begin
          first_err_d = beat_addr(addr_q, rd_beat_q);
        end else if (!err_flag_q && len_bad) begin
          first_err_d = addr_q;
        end else begin
          first_err_d = first_err_q;
        end
        rd_beat_d = beat_cnt;
        state_d   = bus.rd_done ? S_NEXT : S_RD_WAIT;
      end
      S_NEXT: begin
        pass_cnt_d = pass_cnt_q + 16'd1;
        bidx_d     = bidx_q + 32'd1;
        addr_d     = (next_addr >= REGION_END) ? BASE_ADDR : next_addr[ADDR_WIDTH-1:0];
        if (((loops_q != 16'd0) && (pass_cnt_d == loops_q)) || stop) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_beat_d  = (state_d == S_WR_REQ) ? 9'd0 : wr_beat_d;
    done_d     = (state_d == S_DONE) ? 1'b1 : done_d;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    wr_start_d = (state_d == S_WR_REQ);
    rd_start_d = (state_d == S_RD_REQ);
    wr_data_d  = pattern(mode_d, bidx_d, wr_beat_d, addr_d);
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      mode_q      <= 2'd0;
      loops_q     <= 16'd0;
      bidx_q      <= 32'd0;
      addr_q      <= BASE_ADDR;
      wr_beat_q   <= 9'd0;
      rd_beat_q   <= 9'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= {ERR_CNT_WIDTH{1'b0}};
      first_err_q <= {ADDR_WIDTH{1'b0}};
      pass_cnt_q  <= 16'd0;
      wr_start_q  <= 1'b0;
      rd_start_q  <= 1'b0;
      wr_data_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      mode_q      <= mode_d;
      loops_q     <= loops_d;
      bidx_q      <= bidx_d;
      addr_q      <= addr_d;
      wr_beat_q   <= wr_beat_d;
      rd_beat_q   <= rd_beat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_cnt_q  <= pass_cnt_d;
      wr_start_q  <= wr_start_d;
      rd_start_q  <= rd_start_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.wr_start    = wr_start_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_len      = 8'(BURST_LEN);
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_start    = rd_start_q;
  assign bus.rd_addr     = addr_q;
  assign bus.rd_len      = 8'(BURST_LEN);
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_flag        = err_flag_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_addr  = first_err_q;
  assign pass_cnt        = pass_cnt_q;

endmodule

// File: tb/tb_axi_traffic_checker.sv
// Randomized bench: a memory-backed burst slave with fault injection, checked
// against a reference of burst addresses, patterns and expected error results.
module tb_axi_traffic_checker;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          BL     = 16;
  localparam int          ECW    = 4;
  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam logic [31:0] REGION = 32'h0000_0080;
  localparam int          BB     = BL * DW / 8;
  localparam int          NSLOT  = REGION / BB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [15:0]    loops = 16'd0;
  logic           busy, done, err_flag;
  logic [ECW-1:0] err_cnt;
  logic [AW-1:0]  first_err_addr;
  logic [15:0]    pass_cnt;

  axi_traffic_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_traffic_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .REGION_BYTES(REGION),
    .BURST_LEN(BL), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .loops(loops),
    .bus(bus), .busy(busy), .done(done), .err_flag(err_flag), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: burst b lands in slot b mod NSLOT of the window.
  function automatic logic [31:0] exp_addr(input int unsigned b);
    return BASE + (b % NSLOT) * BB;
  endfunction

  function automatic logic [31:0] exp_pat(input logic [1:0] m, input int unsigned b, input int unsigned k);
    int unsigned n;
    n = b * BL + k;
    case (m)
      2'd0:    return n;
      2'd1:    return exp_addr(b) + k * 4;
      2'd2:    return 32'd1 << (n % 32);
      default: return (n % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
  endfunction

  // Fault kinds: 0 none, 1 flip bit 0 of one beat, 2 short burst, 3 long burst, 4 corrupt all beats.
  int          fault_kind = 0;
  int          fault_burst = 0;
  int          fault_beat = 0;
  logic [1:0]  cur_mode = 2'd0;
  int          burst_no = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] mem [logic [31:0]];

  // Burst slave: stores write beats, returns them on read, drives inputs at negedge.
  initial begin
    bit          wr_act, rd_act;
    int          wr_k, wr_dly, rd_k, rd_total, wb, rb;
    logic [31:0] wbase, rbase, a, d;
    wr_act = 0; rd_act = 0; wr_k = 0; wr_dly = 0; rd_k = 0; rd_total = 0; wb = 0; rb = 0;
    wbase = 32'd0; rbase = 32'd0;
    bus.wr_ready = 1'b0; bus.wr_done = 1'b0; bus.rd_vld = 1'b0; bus.rd_done = 1'b0;
    bus.rd_data = 32'd0;
    forever begin
      @(negedge clk);
      bus.wr_ready = 1'b0; bus.wr_done = 1'b0; bus.rd_vld = 1'b0; bus.rd_done = 1'b0;
      bus.rd_data = $urandom;
      if (!rst_n) begin
        wr_act = 0; rd_act = 0;
      end else begin
        if (bus.wr_start) begin
          wr_act = 1; wr_k = 0; wr_dly = $urandom_range(0, 3);
          wb = burst_no; burst_no++; wr_cnt++; wbase = bus.wr_addr;
          check_eq("wr_addr", bus.wr_addr, exp_addr(wb));
          check_eq("wr_len", bus.wr_len, BL);
        end else if (wr_act) begin
          if (wr_k < BL) begin
            if ($urandom_range(0, 2) != 0) begin
              bus.wr_ready = 1'b1;
              check_eq("wr_data", bus.wr_data, exp_pat(cur_mode, wb, wr_k));
              mem[wbase + wr_k * 4] = bus.wr_data;
              wr_k++;
            end
          end else if (wr_dly > 0) begin
            bus.wr_ready = 1'($urandom_range(0, 1));
            wr_dly--;
          end else begin
            bus.wr_done = 1'b1; wr_act = 0;
          end
        end
        if (bus.rd_start) begin
          rd_act = 1; rd_k = 0; rb = wb; rbase = bus.rd_addr; rd_cnt++;
          rd_total = BL;
          if (rb == fault_burst && fault_kind == 2) rd_total = BL - 1;
          if (rb == fault_burst && fault_kind == 3) rd_total = BL + 1;
          check_eq("rd_addr", bus.rd_addr, exp_addr(rb));
        end else if (rd_act) begin
          if (rd_k < rd_total) begin
            if ($urandom_range(0, 3) != 0) begin
              a = rbase + rd_k * 4;
              d = (rd_k < BL && mem.exists(a)) ? mem[a] : $urandom;
              if (rb == fault_burst && fault_kind == 1 && rd_k == fault_beat) d = d ^ 32'd1;
              if (rb == fault_burst && fault_kind == 4) d = ~d;
              bus.rd_vld = 1'b1; bus.rd_data = d; rd_k++;
              if (rd_k == rd_total && $urandom_range(0, 1) == 1) begin
                bus.rd_done = 1'b1; rd_act = 0;
              end
            end
          end else begin
            bus.rd_done = 1'b1; rd_act = 0;
          end
        end
      end
    end
  end

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    check_eq({tag, "_done"}, done, 1);
  endtask

  task automatic kick(input logic [1:0] m, input int nl, input int fk, input int fb, input int fbeat);
    cur_mode = m; fault_kind = fk; fault_burst = fb; fault_beat = fbeat;
    burst_no = 0; wr_cnt = 0; rd_cnt = 0;
    @(negedge clk);
    mode = m; loops = 16'(nl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] m, input int nl,
                     input int fk, input int fb, input int fbeat);
    int          exp_err;
    logic [31:0] exp_first;
    exp_err = 0; exp_first = 32'd0;
    case (fk)
      1: begin exp_err = 1;  exp_first = exp_addr(fb) + fbeat * 4; end
      2: begin exp_err = 1;  exp_first = exp_addr(fb); end
      3: begin exp_err = 1;  exp_first = 32'd0; end
      4: begin exp_err = (BL > (1 << ECW) - 1) ? (1 << ECW) - 1 : BL; exp_first = exp_addr(fb); end
      default: begin exp_err = 0; exp_first = 32'd0; end
    endcase
    kick(m, nl, fk, fb, fbeat);
    wait_done(tag, nl * 400 + 200);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_pass_cnt"}, pass_cnt, nl);
    check_eq({tag, "_err_cnt"}, err_cnt, exp_err);
    check_eq({tag, "_err_flag"}, err_flag, exp_err != 0);
    if (fk != 3) check_eq({tag, "_first_err"}, first_err_addr, exp_first);
    check_eq({tag, "_wr_starts"}, wr_cnt, nl);
    check_eq({tag, "_rd_starts"}, rd_cnt, nl);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_hold"}, done, 1);
  endtask

  initial begin
    int nl;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_wr_addr", bus.wr_addr, BASE);
    check_eq("rst_rd_len", bus.rd_len, BL);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("m0_loops2", 2'd0, 2, 0, 0, 0);
    run("m1_wrap", 2'd1, 3, 0, 0, 0);
    run("m2_flip", 2'd2, 3, 1, 0, 5);
    run("short", 2'd0, 2, 2, 0, 0);
    run("long", 2'd3, 2, 3, 1, 0);
    run("saturate", 2'd1, 2, 4, 1, 0);

    // Infinite run ended by stop; a start edge while busy must not restart it.
    kick(2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 1000 && wr_cnt < 2; i++) @(negedge clk);
    mode = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000 && rd_cnt < 3; i++) @(negedge clk);
    stop = 1'b1;
    wait_done("stop", 1000);
    stop = 1'b0;
    check_eq("stop_pass_cnt", pass_cnt, 3);
    check_eq("stop_wr_starts", wr_cnt, 3);
    check_eq("stop_err_cnt", err_cnt, 0);

    // Reset in the second burst's write phase after an error was recorded.
    kick(2'd0, 4, 1, 0, 3);
    for (int i = 0; i < 1000 && wr_cnt < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_err_cnt", err_cnt, 1);
    check_eq("pre_rst_wr_addr", bus.wr_addr, exp_addr(1));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_err_cnt", err_cnt, 0);
    check_eq("mid_rst_err_flag", err_flag, 0);
    check_eq("mid_rst_first", first_err_addr, 0);
    check_eq("mid_rst_pass_cnt", pass_cnt, 0);
    check_eq("mid_rst_wr_start", bus.wr_start, 0);
    check_eq("mid_rst_wr_addr", bus.wr_addr, BASE);
    check_eq("mid_rst_rd_addr", bus.rd_addr, BASE);
    check_eq("mid_rst_wr_data", bus.wr_data, 0);
    check_eq("mid_rst_wr_len", bus.wr_len, BL);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run("post_rst", 2'd0, 2, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      nl = $urandom_range(1, 5);
      run($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), nl, $urandom_range(0, 4),
          $urandom_range(0, nl - 1), $urandom_range(0, BL - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
